apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max ACCESS cycles waiting for PREADY (timeout build only).
REQ-002 SHALL have port PCLK  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port PRESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports transfer/write  input  1/1  CPU request strobe / 1=write, 0=read.
REQ-005 SHALL have ports addr/wdata  input  32/32  CPU byte address / write data.
REQ-006 SHALL have ports rdata/ready/err  output  32/1/1  read data / one-cycle completion pulse / error flag, valid with ready.
REQ-007 SHALL have ports PADDR/PWDATA  output  32/32, and PWRITE/PENABLE  output  1/1, APB requester signals.
REQ-008 SHALL have ports PSEL0..PSEL3  output  1 each  per-slave selects.
REQ-009 SHALL have ports PRDATA0..PRDATA3  input  32 each, and PREADY0..PREADY3  input  1 each.

Function
REQ-010 SHALL decode addr[31:12]: 0x10000->slave0, 0x10001->slave1, 0x10002->slave2, 0x10003->slave3; any other value is unmapped.
REQ-011 SHALL implement FSM IDLE, SETUP, ACCESS.
REQ-012 SHALL, in IDLE with transfer=1 and a mapped address, latch addr, write, wdata and slave index, then go to SETUP; transfer is ignored outside IDLE.
REQ-013 SHALL, in SETUP, drive selected PSELn=1 and PENABLE=0, then go to ACCESS unconditionally.
REQ-014 SHALL, in ACCESS, drive selected PSELn=1 and PENABLE=1, and stay until the selected PREADYn=1.
REQ-015 SHALL hold PADDR, PWRITE and PWDATA equal to the latched values from SETUP through the final ACCESS cycle.
REQ-016 SHALL, at the ACCESS edge where the selected PREADYn=1, return to IDLE and register ready=1, err=0 for exactly one cycle.
REQ-017 SHALL capture rdata from the selected PRDATAn on that edge for reads, and load rdata=0 for writes.
REQ-018 SHALL keep minimum latency (transfer edge to ready high) at 3 cycles: SETUP, one ACCESS, ready.
REQ-019 SHALL leave all PSELn at 0 and PENABLE at 0 in IDLE, and assert only one PSELn at any time.
REQ-020 SHALL, for an unmapped address in IDLE, assert no PSELn, stay in IDLE, and pulse ready=1, err=1, rdata=0 on the next cycle.
REQ-021 SHALL accept a new transfer in the same cycle that ready is high, giving back-to-back transfers.
REQ-022 SHALL ignore PREADYn and PRDATAn of unselected slaves.

Reset
REQ-023 SHALL, while PRESET=1, force IDLE immediately and drive rdata=0, ready=0, err=0, PADDR=0, PWDATA=0, PWRITE=0, PENABLE=0 and PSEL0..3=0.
REQ-024 SHALL, on reset during SETUP or ACCESS, abandon the transfer with no ready pulse, and accept the first request after release normally.

Configuration
REQ-025 SHALL compile the ACCESS timeout only when APB_MASTER_TIMEOUT_EN is defined.
REQ-026 SHALL, with APB_MASTER_TIMEOUT_EN defined, count ACCESS cycles; once TIMEOUT_CYCLES cycles pass with the selected PREADY low, it drops PSEL/PENABLE, returns to IDLE, and pulses ready=1, err=1, with rdata=0xDEADBEEF for reads or 0 for writes.
REQ-027 SHALL, with APB_MASTER_TIMEOUT_EN defined, clear the timeout counter on every entry to SETUP.
REQ-028 SHALL, with APB_MASTER_TIMEOUT_EN undefined, wait in ACCESS indefinitely and raise err only for unmapped addresses.

Verification
REQ-029 SHALL cover: read addr=0x10003004 with PREADY3 tied to PSEL3 and PRDATA3=0x00000002 -> PSEL3 high for 2 cycles, PENABLE high in the 2nd, ready 3 cycles after transfer, rdata=0x00000002, err=0.
REQ-030 SHALL cover: write addr=0x10001000, wdata=0xA5 with PREADY1 low for 3 ACCESS cycles -> PADDR/PWDATA/PWRITE stable throughout, ready 6 cycles after transfer, rdata=0.
REQ-031 SHALL cover: read addr=0x20000000 -> no PSEL asserted, next cycle ready=1, err=1, rdata=0.
REQ-032 SHALL cover: two reads to slave0 and slave2, the second transfer asserted in the cycle ready is high -> second SETUP directly follows, one PSEL active at a time.
REQ-033 SHALL cover: PRESET pulsed during ACCESS -> all outputs 0 asynchronously, no ready pulse, the next read completes normally.
REQ-034 SHALL cover: with APB_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=8 and PREADY0 held low -> after 8 ACCESS cycles ready=1, err=1, rdata=0xDEADBEEF; without the macro, the FSM stays in ACCESS.

Source files
------------

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master
//  Brief    : Single-requester APB bridge. A CPU-side strobe is decoded onto
//             one of four 4 KiB slave windows at 0x1000_0000..0x1000_3FFF and
//             run as a SETUP/ACCESS handshake. Unmapped addresses complete in
//             one cycle with err=1.
//  Options  : APB_MASTER_TIMEOUT_EN - when defined, an ACCESS phase that sees
//             PREADY low for TIMEOUT_CYCLES cycles is aborted with err=1.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_master
`ifdef APB_MASTER_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        PCLK,
    input  logic        PRESET,
    // CPU side
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    // APB requester side
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    localparam logic [31:0] c_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    state_t      state_q;
    logic [1:0]  slv_q;
    logic [3:0]  psel_q;
    logic        penable_q;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic        pwrite_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        err_q;

`ifdef APB_MASTER_TIMEOUT_EN
    // Counts completed ACCESS cycles with PREADY low; abort when it reaches the last one.
    localparam int unsigned c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [c_CNT_W-1:0] cnt_q;
`endif

    // The four windows share addr[31:14] == 0x04000; addr[13:12] picks the slave.
    logic       w_map_hit;
    logic [1:0] w_map_idx;
    assign w_map_hit = (addr[31:14] == 18'h0_4000);
    assign w_map_idx = addr[13:12];

    // Only the latched slave's PREADY/PRDATA reach the FSM; others are ignored.
    logic        w_sel_ready;
    logic [31:0] w_sel_rdata;
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        case (slv_q)
            2'd0: begin w_sel_ready = PREADY0; w_sel_rdata = PRDATA0; end
            2'd1: begin w_sel_ready = PREADY1; w_sel_rdata = PRDATA1; end
            2'd2: begin w_sel_ready = PREADY2; w_sel_rdata = PRDATA2; end
            default: begin w_sel_ready = PREADY3; w_sel_rdata = PRDATA3; end
        endcase
    end

    // Transfer FSM with all APB and CPU-side outputs registered.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            slv_q     <= 2'd0;
            psel_q    <= 4'd0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            // ready/err are single-cycle pulses unless set below.
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (transfer) begin
                        if (w_map_hit) begin
                            paddr_q   <= addr;
                            pwdata_q  <= wdata;
                            pwrite_q  <= write;
                            slv_q     <= w_map_idx;
                            psel_q    <= 4'b0001 << w_map_idx;
                            penable_q <= 1'b0;
                            state_q   <= S_SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
                            cnt_q     <= '0;
`endif
                        end else begin
                            // Unmapped: never touch the bus, report an error next cycle.
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_sel_ready) begin
                        psel_q    <= 4'd0;
                        penable_q <= 1'b0;
                        ready_q   <= 1'b1;
                        rdata_q   <= pwrite_q ? 32'd0 : w_sel_rdata;
                        state_q   <= S_IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (cnt_q == c_CNT_LAST) begin
                        psel_q    <= 4'd0;
                        penable_q <= 1'b0;
                        ready_q   <= 1'b1;
                        err_q     <= 1'b1;
                        rdata_q   <= pwrite_q ? 32'd0 : c_TIMEOUT_RDATA;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_W'(1);
                    end
`endif
                end
                default: begin
                    psel_q    <= 4'd0;
                    penable_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign PENABLE = penable_q;
    assign PSEL0   = psel_q[0];
    assign PSEL1   = psel_q[1];
    assign PSEL2   = psel_q[2];
    assign PSEL3   = psel_q[3];

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master
//  Brief    : Self-checking bench for apb_master. A behavioural slave model
//             with per-slave wait states drives PREADY/PRDATA; expected
//             latency, rdata and err are derived from the address map and the
//             configured wait count.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit c_TO_EN = 1'b1;
`else
    localparam bit c_TO_EN = 1'b0;
`endif
    localparam int c_TO = 8;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        transfer = 1'b0;
    logic        write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    wire  [31:0] rdata;
    wire         ready;
    wire         err;
    wire  [31:0] PADDR;
    wire  [31:0] PWDATA;
    wire         PWRITE;
    wire         PENABLE;
    wire         PSEL0, PSEL1, PSEL2, PSEL3;
    wire         PREADY0, PREADY1, PREADY2, PREADY3;
    wire  [3:0]  psel_v = {PSEL3, PSEL2, PSEL1, PSEL0};

    // Slave model state
    logic [31:0] prdata [4];
    int          waitc  [4];
    int          acnt   [4];
    logic [3:0]  noise = 4'd0;

    int checks   = 0;
    int failures = 0;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_master #(.TIMEOUT_CYCLES(c_TO)) dut (
`else
    apb_master dut (
`endif
        .PCLK(PCLK), .PRESET(PRESET),
        .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3),
        .PRDATA0(prdata[0]), .PRDATA1(prdata[1]), .PRDATA2(prdata[2]), .PRDATA3(prdata[3]),
        .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3)
    );

    always #5 PCLK = ~PCLK;

    // Selected slave answers after waitc low ACCESS cycles; unselected slaves emit noise.
    assign PREADY0 = PSEL0 ? (acnt[0] >= waitc[0]) : noise[0];
    assign PREADY1 = PSEL1 ? (acnt[1] >= waitc[1]) : noise[1];
    assign PREADY2 = PSEL2 ? (acnt[2] >= waitc[2]) : noise[2];
    assign PREADY3 = PSEL3 ? (acnt[3] >= waitc[3]) : noise[3];

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int k = 0; k < 4; k++) acnt[k] <= 0;
        end else begin
            for (int k = 0; k < 4; k++) acnt[k] <= (psel_v[k] && PENABLE) ? acnt[k] + 1 : 0;
        end
    end

    always @(negedge PCLK) noise <= 4'($urandom);

    // Run one transfer starting at the current negedge; returns at the negedge where ready is seen.
    task automatic run_xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input string tag);
        bit          mapped;
        int          s;
        int          lat;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [3:0]  exp_psel;
        bit          done;
        mapped = (a[31:12] >= 20'h10000) && (a[31:12] <= 20'h10003);
        s = 0;
        if (!mapped) begin
            lat = 1; exp_err = 1'b1; exp_rd = 32'd0;
        end else begin
            s = int'(a[31:12] - 20'h10000);
            if (c_TO_EN && waitc[s] >= c_TO) begin
                lat = c_TO + 2; exp_err = 1'b1; exp_rd = w ? 32'd0 : 32'hDEAD_BEEF;
            end else begin
                lat = waitc[s] + 3; exp_err = 1'b0; exp_rd = w ? 32'd0 : prdata[s];
            end
        end
        exp_psel = mapped ? (4'b0001 << s) : 4'b0000;
        transfer = 1'b1; addr = a; write = w; wdata = d;
        @(negedge PCLK);
        done = 1'b0;
        for (int k = 1; k <= lat + 5 && !done; k++) begin
            if (ready === 1'b1) begin
                checks++;
                if (k != lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", tag, k, lat); end
                checks++;
                if (rdata !== exp_rd) begin failures++; $display("FAIL %s rdata got=%h exp=%h", tag, rdata, exp_rd); end
                checks++;
                if (err !== exp_err) begin failures++; $display("FAIL %s err got=%b exp=%b", tag, err, exp_err); end
                checks++;
                if ({psel_v, PENABLE} !== 5'd0) begin failures++; $display("FAIL %s idle_bus got=%b exp=00000", tag, {psel_v, PENABLE}); end
                transfer = 1'b0;
                done = 1'b1;
            end else begin
                checks++;
                if (k >= lat) begin
                    failures++; $display("FAIL %s ready_missing cycle=%0d exp_at=%0d", tag, k, lat);
                    transfer = 1'b0;
                    done = 1'b1;
                end else begin
                    checks++;
                    if (psel_v !== exp_psel) begin failures++; $display("FAIL %s psel c%0d got=%b exp=%b", tag, k, psel_v, exp_psel); end
                    checks++;
                    if (PENABLE !== (k >= 2)) begin failures++; $display("FAIL %s penable c%0d got=%b exp=%b", tag, k, PENABLE, (k >= 2)); end
                    checks++;
                    if ({PADDR, PWDATA, PWRITE} !== {a, d, w}) begin
                        failures++; $display("FAIL %s hold c%0d got=%h/%h/%b exp=%h/%h/%b", tag, k, PADDR, PWDATA, PWRITE, a, d, w);
                    end
                    // Requests outside IDLE must be ignored.
                    transfer = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom; write = 1'($urandom);
                    @(negedge PCLK);
                end
            end
        end
        transfer = 1'b0;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        checks++;
        if ({rdata, ready, err, PADDR, PWDATA, PWRITE, PENABLE, psel_v} !== 104'd0) begin
            failures++; $display("FAIL reset_values got=%h exp=0", {rdata, ready, err, PADDR, PWDATA, PWRITE, PENABLE, psel_v});
        end
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        checks++;
        if ({ready, err, psel_v, PENABLE} !== 7'd0) begin
            failures++; $display("FAIL post_reset_idle got=%b exp=0", {ready, err, psel_v, PENABLE});
        end
    endtask

    task automatic test_read_zero_wait();
        waitc[3] = 0; prdata[3] = 32'h0000_0002;
        prdata[0] = $urandom; prdata[1] = $urandom; prdata[2] = $urandom;
        run_xfer(32'h1000_3004, 1'b0, 32'h0, "rd_s3_nowait");
        @(negedge PCLK);
    endtask

    task automatic test_write_wait();
        waitc[1] = 3;
        run_xfer(32'h1000_1000, 1'b1, 32'h0000_00A5, "wr_s1_wait3");
        @(negedge PCLK);
    endtask

    task automatic test_unmapped();
        run_xfer(32'h2000_0000, 1'b0, 32'h0, "unmapped_rd");
        @(negedge PCLK);
        run_xfer(32'h1000_4000, 1'b1, 32'h1234, "unmapped_edge");
        @(negedge PCLK);
    endtask

    task automatic test_back_to_back();
        waitc[0] = 0; waitc[2] = 1;
        prdata[0] = 32'hCAFE_0000; prdata[2] = 32'h0000_F00D;
        run_xfer(32'h1000_0008, 1'b0, 32'h0, "b2b_first");
        run_xfer(32'h1000_2010, 1'b0, 32'h0, "b2b_second");
        @(negedge PCLK);
    endtask

    task automatic test_reset_mid();
        waitc[2] = 6; prdata[2] = $urandom;
        transfer = 1'b1; addr = 32'h1000_2010; write = 1'b0;
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        checks++;
        if ({psel_v, PENABLE} !== 5'b0100_1) begin failures++; $display("FAIL rstmid_access got=%b exp=01001", {psel_v, PENABLE}); end
        #2 PRESET = 1'b1;
        #1;
        checks++;
        if ({rdata, ready, err, PADDR, PWDATA, PWRITE, PENABLE, psel_v} !== 104'd0) begin
            failures++; $display("FAIL rstmid_async got=%h exp=0", {rdata, ready, err, PADDR, PWDATA, PWRITE, PENABLE, psel_v});
        end
        @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            checks++;
            if ({ready, psel_v, PENABLE} !== 6'd0) begin failures++; $display("FAIL rstmid_quiet c%0d got=%b exp=0", i, {ready, psel_v, PENABLE}); end
        end
        waitc[2] = 1; prdata[2] = 32'h5A5A_1234;
        run_xfer(32'h1000_2FFC, 1'b0, 32'h0, "rstmid_next");
        @(negedge PCLK);
    endtask

    task automatic test_timeout();
`ifdef APB_MASTER_TIMEOUT_EN
        waitc[0] = 1000;
        run_xfer(32'h1000_0020, 1'b0, 32'h0, "to_read");
        @(negedge PCLK);
        run_xfer(32'h1000_0024, 1'b1, 32'h77, "to_write");
        @(negedge PCLK);
        // One short of the limit must complete normally: the counter restarts per transfer.
        waitc[0] = c_TO - 1; prdata[0] = 32'h0BAD_F00D;
        run_xfer(32'h1000_0028, 1'b0, 32'h0, "to_just_under");
        @(negedge PCLK);
`else
        waitc[0] = 1000;
        transfer = 1'b1; addr = 32'h1000_0020; write = 1'b0;
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            checks++;
            if ({ready, err, psel_v, PENABLE} !== 7'b00_0001_1) begin
                failures++; $display("FAIL no_timeout_wait c%0d got=%b exp=0000011", i, {ready, err, psel_v, PENABLE});
            end
        end
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        waitc[0] = 0;
        @(negedge PCLK);
`endif
    endtask

    task automatic test_random();
        int          r;
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 4);
            a = $urandom;
            if (r == 4) a[31:28] = 4'h3;
            else a[31:12] = 20'h10000 + 20'(r);
            for (int k = 0; k < 4; k++) prdata[k] = $urandom;
            if (r < 4) waitc[r] = $urandom_range(0, 4);
            run_xfer(a, 1'($urandom), $urandom, "random");
            if ($urandom_range(0, 1) == 0) @(negedge PCLK);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin prdata[k] = '0; waitc[k] = 0; end
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
